sum_uart_tx: RTL

Downstream stage of the adder datapath. It takes each 8-bit sum result through a valid/ready handshake and serialises it as an 8N1 UART frame on one output pin, so results can be read off-chip with a standard serial terminal. One holding register lets the next result be accepted while the current frame is still shifting out.

---
 rtl/sum_uart_pkg.sv | 15 +
 rtl/sum_uart_baud.sv | 31 +++
 rtl/sum_uart_tx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sum_uart_pkg.sv
// rtl/sum_uart_pkg.sv - shared types and constants for the sum UART transmitter
package sum_uart_pkg;

    localparam int DATA_W               = 8;
    localparam int FRAME_BITS           = 10;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/sum_uart_baud.sv
// rtl/sum_uart_baud.sv - baud counter with synchronous clear and one-cycle wrap tick
module sum_uart_baud
    import sum_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Tick is suppressed while cleared so a state entry never sees a stale wrap.
    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/sum_uart_tx.sv
// rtl/sum_uart_tx.sv - 8N1 UART serialiser for adder sum bytes with one holding register
module sum_uart_tx
    import sum_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter bit CHANGE_ONLY  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              ovr_clr,
    output logic              tx,
    output logic              busy,
    output logic              overrun
);

    uart_state_t       state, state_nxt;
    logic [DATA_W-1:0] hold_data;
    logic              hold_full;
    logic [DATA_W-1:0] last_byte;
    logic              last_valid;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [2:0]        bit_idx, bit_idx_nxt;
    logic              tx_nxt;
    logic              load;
    logic              tick;
    logic              accept;
    logic              dup;

    sum_uart_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state == IDLE),
        .tick (tick)
    );

    assign in_ready = !hold_full;
    assign busy     = (state != IDLE) || hold_full;
    assign accept   = in_valid && in_ready;
    assign dup      = CHANGE_ONLY && last_valid && (in_data == last_byte);

    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        load        = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    state_nxt = START;
                    load      = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = 3'd0;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_nxt = shreg >> 1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                // A waiting byte chains straight into the next start bit.
                if (tick) begin
                    if (hold_full) begin
                        state_nxt = START;
                        load      = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (load) begin
            shreg_nxt = hold_data;
        end
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= 3'd0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_idx <= bit_idx_nxt;
            tx      <= tx_nxt;
        end
    end

    // Accept and drain are mutually exclusive because in_ready is !hold_full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_full  <= 1'b0;
            last_byte  <= '0;
            last_valid <= 1'b0;
        end else begin
            if (load) begin
                hold_full <= 1'b0;
            end else if (accept && !dup) begin
                hold_full <= 1'b1;
                hold_data <= in_data;
            end
            if (accept) begin
                last_byte  <= in_data;
                last_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule
